// File: rtl/valve_step_sequencer_pkg.sv
// valve_step_sequencer_pkg: shared unit encodings, step-word layout and FSM states
package valve_step_sequencer_pkg;

    localparam logic [2:0] UNIT_MS  = 3'd0;
    localparam logic [2:0] UNIT_S   = 3'd1;
    localparam logic [2:0] UNIT_MIN = 3'd2;
    localparam logic [2:0] UNIT_HR  = 3'd3;
    localparam logic [2:0] UNIT_DAY = 3'd4;

    localparam int DELAY_W = 6;
    localparam int UNIT_W  = 3;
    localparam int CTRL_W  = 1 + UNIT_W + DELAY_W;

    // Control header that sits above the valve field in a step word.
    typedef struct packed {
        logic              last;
        logic [UNIT_W-1:0]  unit;
        logic [DELAY_W-1:0] delay;
    } step_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_APPLY,
        ST_WAIT,
        ST_RELEASE
    } state_t;

    function automatic logic unit_ok(input logic [UNIT_W-1:0] u);
        return u <= UNIT_DAY;
    endfunction

endpackage

// File: rtl/valve_step_sequencer_prog_mem.sv
// seq_prog_mem: DEPTH x WIDTH simple dual-port program RAM with synchronous read
// ports: we/waddr/wdata write port; raddr in, rdata out one cycle later.
module seq_prog_mem #(
    parameter int WIDTH  = 26,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/valve_step_sequencer.sv
// valve_step_sequencer: steps the valve array through a stored program timed by the external delay counter
// ports: prog_we/prog_addr/prog_wdata load the program while idle; run_start/abort/loop_en control runs;
//        delay/delay_unit/delay_start/count_done drive the delay counter;
//        valves/step_idx/busy/seq_done/err report to the valve driver and host.
module valve_step_sequencer
    import valve_step_sequencer_pkg::*;
#(
    parameter int                  N_VALVES  = 16,
    parameter int                  DEPTH     = 16,
    parameter int                  ADDR_W    = 4,
    parameter logic [N_VALVES-1:0] SAFE_MASK = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_we,
    input  logic [ADDR_W-1:0]          prog_addr,
    input  logic [N_VALVES+CTRL_W-1:0] prog_wdata,
    input  logic                       run_start,
    input  logic                       abort,
    input  logic                       loop_en,
    output logic [DELAY_W-1:0]         delay,
    output logic [UNIT_W-1:0]          delay_unit,
    output logic                       delay_start,
    input  logic                       count_done,
    output logic [N_VALVES-1:0]        valves,
    output logic [ADDR_W-1:0]          step_idx,
    output logic                       busy,
    output logic                       seq_done,
    output logic                       err
);

    localparam int WORD_W = N_VALVES + CTRL_W;

    state_t              state_q, state_d;
    logic [N_VALVES-1:0] valves_q, valves_d;
    logic [DELAY_W-1:0]  delay_q, delay_d;
    logic [UNIT_W-1:0]   unit_q, unit_d;
    logic                start_q, start_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                last_q, last_d;
    logic [WORD_W-1:0]   rdata;
    step_t               hdr;
    logic [N_VALVES-1:0] word_valves;
    logic                bad, adv, at_end, finish;

    assign hdr         = step_t'(rdata[WORD_W-1:N_VALVES]);
    assign word_valves = rdata[N_VALVES-1:0];

    // Read address is step_idx, which is stable through FETCH, so rdata is valid in APPLY.
    seq_prog_mem #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .we   (prog_we && state_q == ST_IDLE),
        .waddr(prog_addr),
        .wdata(prog_wdata),
        .raddr(idx_q),
        .rdata(rdata)
    );

    assign bad    = state_q == ST_APPLY && !unit_ok(hdr.unit);
    assign adv    = (state_q == ST_APPLY && !bad && hdr.delay == '0) ||
                    (state_q == ST_RELEASE && !count_done);
    // In RELEASE the last flag comes from the copy latched in APPLY.
    assign at_end = (state_q == ST_APPLY ? hdr.last : last_q) || idx_q == ADDR_W'(DEPTH - 1);
    assign finish = adv && at_end && !loop_en;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort || bad) state_d = ST_IDLE;
        else if (adv) state_d = finish ? ST_IDLE : ST_FETCH;
        else if (state_q == ST_IDLE) state_d = run_start ? ST_FETCH : ST_IDLE;
        else if (state_q == ST_FETCH) state_d = ST_APPLY;
        else if (state_q == ST_APPLY) state_d = ST_WAIT;
        else if (state_q == ST_WAIT) state_d = count_done ? ST_RELEASE : ST_WAIT;
    end

    always_comb begin
        valves_d = valves_q;
        delay_d  = delay_q;
        unit_d   = unit_q;
        start_d  = start_q;
        idx_d    = idx_q;
        err_d    = err_q;
        last_d   = last_q;
        done_d   = 1'b0;
        if (abort) begin
            valves_d = SAFE_MASK;
            start_d  = 1'b0;
        end else begin
            if (state_q == ST_IDLE && run_start) begin
                idx_d = '0;
                err_d = 1'b0;
            end
            if (bad) begin
                err_d    = 1'b1;
                valves_d = SAFE_MASK;
            end else if (state_q == ST_APPLY) begin
                valves_d = word_valves;
                delay_d  = hdr.delay;
                unit_d   = hdr.unit;
                last_d   = hdr.last;
                start_d  = hdr.delay != '0;
            end
            if (state_q == ST_WAIT && count_done) start_d = 1'b0;
            if (finish) begin
                valves_d = SAFE_MASK;
                done_d   = 1'b1;
            end else if (adv) begin
                idx_d = at_end ? '0 : idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valves_q <= SAFE_MASK;
            delay_q  <= '0;
            unit_q   <= '0;
            start_q  <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            valves_q <= valves_d;
            delay_q  <= delay_d;
            unit_q   <= unit_d;
            start_q  <= start_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            err_q    <= err_d;
            last_q   <= last_d;
        end
    end

    assign valves      = valves_q;
    assign delay       = delay_q;
    assign delay_unit  = unit_q;
    assign delay_start = start_q;
    assign step_idx    = idx_q;
    assign seq_done    = done_q;
    assign err         = err_q;
    assign busy        = state_q != ST_IDLE;

endmodule

// File: tb/tb_valve_step_sequencer.sv
// tb_valve_step_sequencer: scoreboard bench with a time-scaled delay counter model
module tb_valve_step_sequencer;
    import valve_step_sequencer_pkg::*;

    localparam int TICK = 20;
    localparam int ANY  = 1 << 30;

    logic        clk = 1'b0, rst = 1'b1, prog_we = 1'b0, run_start = 1'b0, abort = 1'b0;
    logic        loop_en = 1'b0, count_done = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [25:0] prog_wdata = '0;
    logic [5:0]  delay;
    logic [2:0]  delay_unit;
    logic        delay_start, busy, seq_done, err;
    logic [15:0] valves;
    logic [3:0]  step_idx;

    always #5 clk = ~clk;

    valve_step_sequencer dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .run_start(run_start), .abort(abort), .loop_en(loop_en), .delay(delay),
        .delay_unit(delay_unit), .delay_start(delay_start), .count_done(count_done),
        .valves(valves), .step_idx(step_idx), .busy(busy), .seq_done(seq_done), .err(err)
    );

    typedef struct { logic [15:0] v; int lo; int hi; } exp_t;
    exp_t sb_q[$];
    exp_t cur = '{16'h0, 0, ANY};
    int   idx_q[$];
    int   errors = 0, checks = 0, hold = 0, ds_rises = 0, done_cnt = 0;
    int   extra_hold = 0, cnt = 0, hold_cnt = 0;
    logic        mon_en = 1'b0, prev_ds = 1'b0;
    logic [15:0] prev_v = '0;
    logic [3:0]  prev_idx = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int ticks(input logic [2:0] u);
        return u == UNIT_MS ? TICK : u == UNIT_S ? 2 * TICK : u == UNIT_MIN ? 3 * TICK :
               u == UNIT_HR ? 4 * TICK : 5 * TICK;
    endfunction

    // Counter model: done after delay*ticks cycles of delay_start, held extra_hold cycles after it drops.
    always @(posedge clk) begin
        if (!delay_start) begin
            cnt <= 0;
            if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
            else count_done <= 1'b0;
        end else if (!count_done) begin
            if (cnt == int'(delay) * ticks(delay_unit) - 1) begin
                count_done <= 1'b1;
                hold_cnt   <= extra_hold;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (valves != prev_v) begin
                check($sformatf("hold of 0x%0h=%0d in %0d..%0d", prev_v, hold, cur.lo, cur.hi),
                      32'(hold >= cur.lo && hold <= cur.hi), 1);
                if (sb_q.size() == 0) begin
                    check($sformatf("sb_extra valves=0x%0h", valves), sb_q.size(), 1);
                    cur = '{valves, 0, ANY};
                end else begin
                    cur = sb_q.pop_front();
                    check("valves", valves, cur.v);
                end
                hold   = 1;
                prev_v = valves;
            end else begin
                hold++;
            end
            if (step_idx != prev_idx) begin
                if (idx_q.size() == 0) check("idx_extra", idx_q.size(), 1);
                else begin
                    int e;
                    e = idx_q.pop_front();
                    check("step_idx", step_idx, e);
                end
                prev_idx = step_idx;
            end
            if (delay_start && !prev_ds) begin
                ds_rises++;
                check("ds_rise_done", count_done, 0);
            end
            prev_ds = delay_start;
            if (seq_done) begin
                done_cnt++;
                check("busy_at_done", busy, 0);
                check("safe_at_done", valves, 16'h0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic last, input logic [2:0] u, input logic [5:0] d,
                        input logic [15:0] v);
        prog_we    = 1'b1;
        prog_addr  = 4'(a);
        prog_wdata = {last, u, d, v};
        cycles(1);
        prog_we    = 1'b0;
    endtask

    task automatic run();
        run_start = 1'b1;
        cycles(1);
        run_start = 1'b0;
    endtask

    task automatic push(input logic [15:0] v, input int lo, input int hi);
        sb_q.push_back('{v, lo, hi});
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            cycles(1);
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic check_reset(input string t);
        check({t, "valves"}, valves, 16'h0);
        check({t, "delay"}, delay, 0);
        check({t, "delay_unit"}, delay_unit, 0);
        check({t, "delay_start"}, delay_start, 0);
        check({t, "step_idx"}, step_idx, 0);
        check({t, "busy"}, busy, 0);
        check({t, "seq_done"}, seq_done, 0);
        check({t, "err"}, err, 0);
    endtask

    task automatic begin_test();
        ds_rises = 0;
        done_cnt = 0;
    endtask

    task automatic end_test(input string t, input int rises, input int dones);
        cycles(3);
        check({t, "_ds_rises"}, ds_rises, rises);
        check({t, "_seq_done_cnt"}, done_cnt, dones);
        check({t, "_sb_left"}, sb_q.size(), 0);
        check({t, "_idx_left"}, idx_q.size(), 0);
    endtask

    initial begin
        cycles(3);
        check_reset("rst_");
        rst    = 1'b0;
        mon_en = 1'b1;
        cycles(2);

        // single 2 ms step, then safe pattern and one seq_done
        load(0, 1'b1, UNIT_MS, 6'd2, 16'h0003);
        push(16'h0003, 2 * TICK + 1, 2 * TICK + 5);
        push(16'h0000, 0, ANY);
        begin_test();
        run();
        check("t1_busy", busy, 1);
        wait_idle("t1_idle");
        end_test("t1", 1, 1);

        // 1 ms, zero-delay, 1 ms (last)
        load(0, 1'b0, UNIT_MS, 6'd1, 16'h0011);
        load(1, 1'b0, UNIT_MS, 6'd0, 16'h0022);
        load(2, 1'b1, UNIT_MS, 6'd1, 16'h0044);
        push(16'h0011, TICK + 4, TICK + 6);
        push(16'h0022, 2, 2);
        push(16'h0044, TICK + 2, TICK + 4);
        push(16'h0000, 0, ANY);
        idx_q.push_back(1);
        idx_q.push_back(2);
        begin_test();
        run();
        wait_idle("t2_idle");
        end_test("t2", 2, 1);

        // bad unit
        load(0, 1'b1, 3'd5, 6'd3, 16'h00ff);
        idx_q.push_back(0);
        begin_test();
        run();
        cycles(3);
        check("t3_err", err, 1);
        check("t3_busy", busy, 0);
        check("t3_valves", valves, 16'h0);
        check("t3_delay_start", delay_start, 0);
        end_test("t3", 0, 0);

        // looping two-step program, then abort
        load(0, 1'b0, UNIT_MS, 6'd1, 16'h0101);
        load(1, 1'b1, UNIT_MS, 6'd1, 16'h0202);
        loop_en = 1'b1;
        push(16'h0101, TICK + 3, TICK + 7);
        push(16'h0202, TICK + 3, TICK + 7);
        push(16'h0101, TICK + 3, TICK + 7);
        push(16'h0202, TICK + 3, TICK + 7);
        push(16'h0101, 0, ANY);
        push(16'h0000, 0, ANY);
        idx_q.push_back(1);
        idx_q.push_back(0);
        idx_q.push_back(1);
        idx_q.push_back(0);
        begin_test();
        run();
        check("t4_err_clear", err, 0);
        cycles(105);
        abort = 1'b1;
        cycles(1);
        abort = 1'b0;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_ds", delay_start, 0);
        check("t4_abort_valves", valves, 16'h0);
        loop_en = 1'b0;
        end_test("t4", 5, 0);

        // count_done lingers 3 cycles after delay_start drops
        load(0, 1'b0, UNIT_MS, 6'd1, 16'h0505);
        load(1, 1'b1, UNIT_MS, 6'd1, 16'h0a0a);
        extra_hold = 3;
        push(16'h0505, TICK + 7, TICK + 9);
        push(16'h0a0a, TICK + 5, TICK + 7);
        push(16'h0000, 0, ANY);
        idx_q.push_back(1);
        begin_test();
        run();
        wait_idle("t5_idle");
        extra_hold = 0;
        end_test("t5", 2, 1);

        // writes during a run are ignored; rst in WAIT; rerun the same program
        idx_q.push_back(0);
        push(16'h0505, 0, ANY);
        push(16'h0000, 0, ANY);
        begin_test();
        run();
        cycles(5);
        load(0, 1'b1, UNIT_MS, 6'd0, 16'hdead);
        load(1, 1'b1, UNIT_MS, 6'd0, 16'hbeef);
        cycles(5);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check_reset("t6_rst_");
        push(16'h0505, TICK + 4, TICK + 6);
        push(16'h0a0a, TICK + 2, TICK + 4);
        push(16'h0000, 0, ANY);
        idx_q.push_back(1);
        run();
        wait_idle("t6_idle");
        end_test("t6", 3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 30000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
